tick_led_sequencer: RTL
=======================

TICK_LED_SEQUENCER -- requirements
Module: tick_led_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: number of LED outputs; legal range 2..32.
REQ-002 Parameter HOLD, default 3: ticks per LED step; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port tick, input, 1: single-cycle enable pulse from the upstream divide-by-N FSM; arbitrary spacing, including back-to-back.
REQ-006 Port start, input, 1: level-sampled start request.
REQ-007 Port stop, input, 1: level-sampled stop request.
REQ-008 Port led, output, WIDTH: one-hot LED pattern, or all zeros when idle.
REQ-009 Port busy, output, 1: high in any running state.
REQ-010 Port wrap, output, 1: single-cycle pulse on each direction reversal.

Function
REQ-011 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-012 FSM states SHALL be IDLE, LEFT and RIGHT; unreachable encodings SHALL return to IDLE on the next clock.
REQ-013 IDLE behaviour SHALL be: led=0, busy=0, wrap=0, hold counter=0.
REQ-014 IDLE with start=1 and stop=0 SHALL go to LEFT on the next edge, with led=1 (bit 0), busy=1 and hold counter=0.
REQ-015 start while in LEFT or RIGHT SHALL be ignored: no restart and no counter clear.
REQ-016 stop=1 in any state SHALL force IDLE on the next edge with led=0, busy=0 and wrap=0; stop outranks start and tick in the same cycle.
REQ-017 In LEFT/RIGHT, each cycle with tick=1 SHALL increment the hold counter; a cycle with tick=1 and counter==HOLD-1 is a step cycle, which clears the counter to 0.
REQ-018 With HOLD=1, every tick SHALL be a step cycle.
REQ-019 Step in LEFT with led[WIDTH-1]=0 SHALL shift led left by one bit.
REQ-020 Step in LEFT with led[WIDTH-1]=1 SHALL go to RIGHT with led=bit WIDTH-2 and wrap=1 for exactly that next cycle.
REQ-021 Step in RIGHT with led[0]=0 SHALL shift led right by one bit.
REQ-022 Step in RIGHT with led[0]=1 SHALL go to LEFT with led=bit 1 and wrap=1 for exactly that next cycle.
REQ-023 led SHALL be exactly one-hot in LEFT/RIGHT at all times; a non-step cycle SHALL leave led, state and wrap=0 unchanged.
REQ-024 Latency SHALL be exactly one clock from a step-cycle tick to the led update.
REQ-025 The hold counter width SHALL be 8 bits, and the counter SHALL never exceed HOLD-1.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, led=0, busy=0, wrap=0 and hold counter=0, including mid-sequence.
REQ-027 After rst_n deasserts, the block SHALL stay in IDLE until a start is sampled on a rising edge; tick alone SHALL have no effect.

Verification (WIDTH=8, HOLD=2 unless stated)
REQ-028 Reset, then 10 ticks with no start -> led=8'h00, busy=0, wrap never asserted.
REQ-029 start pulse, then ticks on every 4th cycle -> led=01 after start, 02 after 2nd tick, 80 after 14th tick, 40 with a one-cycle wrap=1 after 16th tick, then 01 after 28th tick and 02 with wrap=1 after 30th tick.
REQ-030 HOLD=1 with tick held high continuously -> led advances every cycle, 01->02->...->80->40, with wrap=1 only in the cycle led=40.
REQ-031 stop and a step-cycle tick in the same cycle while led=10 -> next cycle led=00, busy=0, wrap=0; a start in that same cycle is ignored.
REQ-032 rst_n pulled low mid-clock-period while led=20 -> led=00 and busy=0 before the next rising edge; after release, start gives led=01.
REQ-033 start asserted again while running at led=04 with the counter at 1 -> no restart; the next tick steps led to 08.

Source files
------------

// File: rtl/tick_led_sequencer.sv
// tick_led_sequencer: bounces a one-hot LED left and right, one step every HOLD ticks.
module tick_led_sequencer #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_led;
  logic             r_busy;
  logic             r_wrap;
  logic [7:0]       r_cnt;
  logic             w_step;
  assign w_step = tick && (r_cnt == 8'(HOLD - 1));
  assign led    = r_led;
  assign busy   = r_busy;
  assign wrap   = r_wrap;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else if (stop) begin
      r_state <= IDLE;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= start ? LEFT : IDLE;
          r_led   <= start ? WIDTH'(1) : '0;
          r_busy  <= start;
          r_wrap  <= 1'b0;
          r_cnt   <= '0;
        end
        LEFT: begin
          r_wrap <= w_step && r_led[WIDTH-1];
          if (tick) r_cnt <= w_step ? 8'd0 : r_cnt + 8'd1;
          if (w_step) begin
            r_state <= r_led[WIDTH-1] ? RIGHT : LEFT;
            r_led   <= r_led[WIDTH-1] ? WIDTH'(1) << (WIDTH - 2) : r_led << 1;
          end
        end
        RIGHT: begin
          r_wrap <= w_step && r_led[0];
          if (tick) r_cnt <= w_step ? 8'd0 : r_cnt + 8'd1;
          if (w_step) begin
            r_state <= r_led[0] ? LEFT : RIGHT;
            r_led   <= r_led[0] ? WIDTH'(2) : r_led >> 1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_led   <= '0;
          r_busy  <= 1'b0;
          r_wrap  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end
endmodule
